// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared CPU control definitions: sequencer state encoding, symbolic stage
// indices for the default five-stage datapath, and the default stage count.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    // Stage indices of the default datapath.
    typedef enum int {
        STG_IF = 0,
        STG_RF = 1,
        STG_EX = 2,
        STG_DM = 3,
        STG_PC = 4
    } stage_idx_t;

    localparam int NUM_STAGES_DEF = 5;

endpackage

// File: rtl/stage_wdog.sv
// ---------------------------------------------------------------------------
// stage_wdog
// Per-stage wait counter. Counts cycles while enable=1 and restarts from zero
// whenever clear=1. expired is high in the TIMEOUT-th consecutive cycle that
// the same stage has been active, so the caller can still let a done in that
// same cycle win.
// Ports:
//   clk      in   clock
//   nreset   in   synchronous, active-high reset
//   clear    in   restart the count (stage change or not running)
//   enable   in   count this cycle
//   expired  out  current cycle is the last one allowed without done
// ---------------------------------------------------------------------------
module stage_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (nreset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + W'(1);
        end
    end

    // count_reg holds the number of earlier cycles spent in this stage.
    assign expired = (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Multi-cycle CPU stage controller. Issues one-hot stage go strobes, advances
// on per-stage done, skips stages chosen by decode, supports flush, run/stop,
// a watchdog that halts on a stuck stage, and retire/cycle counters.
// Ports:
//   clk, nreset       clock, synchronous active-high reset
//   run_i             start / continue issuing instructions
//   stage_done_i      per-stage completion (only the active bit matters)
//   skip_mask_i       stages to bypass, sampled when DECODE_STAGE completes
//   flush_i           abort the current instruction
//   go_o, stage_o     one-hot active stage and its index
//   busy_o            sequencer is running
//   retire_o          last executed stage completes this cycle
//   instr_count_o     retired instruction count
//   cycle_count_o     busy cycle count
//   timeout_o         sticky watchdog flag
// ---------------------------------------------------------------------------
module stage_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = NUM_STAGES_DEF,
    parameter int DECODE_STAGE = STG_RF,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          run_i,
    input  logic [NUM_STAGES-1:0]         stage_done_i,
    input  logic [NUM_STAGES-1:0]         skip_mask_i,
    input  logic                          flush_i,
    output logic [NUM_STAGES-1:0]         go_o,
    output logic [$clog2(NUM_STAGES)-1:0] stage_o,
    output logic                          busy_o,
    output logic                          retire_o,
    output logic [CNT_W-1:0]              instr_count_o,
    output logic [CNT_W-1:0]              cycle_count_o,
    output logic                          timeout_o
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] ALL_ONES   = {NUM_STAGES{1'b1}};
    // Only stages after decode may be skipped.
    localparam logic [NUM_STAGES-1:0] SKIP_ALLOW = ALL_ONES << (DECODE_STAGE + 1);

    seq_state_t              state_reg;
    logic [IDX_W-1:0]        stage_reg;
    logic [NUM_STAGES-1:0]   skip_reg;
    logic [CNT_W-1:0]        instr_count_reg;
    logic [CNT_W-1:0]        cycle_count_reg;
    logic                    timeout_reg;

    logic                    done;
    logic [NUM_STAGES-1:0]   eff_skip;
    logic [NUM_STAGES-1:0]   cand;
    logic [IDX_W:0]          pick;
    logic                    has_next;
    logic [IDX_W-1:0]        next_idx;
    logic                    wd_expired;

    // Lowest set bit of cand; MSB of the result flags that one was found.
    function automatic logic [IDX_W:0] next_stage(input logic [NUM_STAGES-1:0] c);
        logic [IDX_W:0] result;
        result = '0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (c[j]) begin
                result = {1'b1, IDX_W'(j)};
            end
        end
        return result;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_go
            assign go_o[gi] = (state_reg == RUN) && (stage_reg == IDX_W'(gi));
        end
    endgenerate

    assign busy_o        = (state_reg == RUN);
    assign stage_o       = stage_reg;
    assign instr_count_o = instr_count_reg;
    assign cycle_count_o = cycle_count_reg;
    assign timeout_o     = timeout_reg;

    // go_o is all-zero outside RUN, so this also gates done by state.
    assign done = |(stage_done_i & go_o);

    // While decode is completing, the mask being latched already steers the
    // choice of the following stage.
    assign eff_skip = ((stage_reg == IDX_W'(DECODE_STAGE)) ? skip_mask_i : skip_reg) & SKIP_ALLOW;
    assign cand     = ~eff_skip & (ALL_ONES << (int'(stage_reg) + 1));
    assign pick     = next_stage(cand);
    assign has_next = pick[IDX_W];
    assign next_idx = pick[IDX_W-1:0];

    // Flush takes priority over completion, so no retire on a flushed cycle.
    assign retire_o = done && !flush_i && !has_next;

    stage_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .nreset  (nreset),
        .clear   ((state_reg != RUN) || done || flush_i),
        .enable  (busy_o),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_reg       <= IDLE;
            stage_reg       <= IDX_W'(STG_IF);
            skip_reg        <= '0;
            instr_count_reg <= '0;
            cycle_count_reg <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run_i) begin
                        state_reg <= RUN;
                        stage_reg <= IDX_W'(STG_IF);
                    end
                end
                RUN: begin
                    cycle_count_reg <= cycle_count_reg + CNT_W'(1);
                    if (flush_i) begin
                        stage_reg <= IDX_W'(STG_IF);
                        skip_reg  <= '0;
                        state_reg <= run_i ? RUN : IDLE;
                    end else if (done) begin
                        if (has_next) begin
                            stage_reg <= next_idx;
                            if (stage_reg == IDX_W'(DECODE_STAGE)) begin
                                skip_reg <= eff_skip;
                            end
                        end else begin
                            instr_count_reg <= instr_count_reg + CNT_W'(1);
                            stage_reg       <= IDX_W'(STG_IF);
                            skip_reg        <= '0;
                            state_reg       <= run_i ? RUN : IDLE;
                        end
                    end else if (wd_expired) begin
                        // Stage index is kept so the stuck stage is visible.
                        state_reg   <= HALT;
                        timeout_reg <= 1'b1;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer
// Drives directed and random stimulus into stage_sequencer. For every cycle a
// reference model written from the sequencing rules produces the expected
// outputs, which are queued; a monitor on the falling edge pops and compares
// them against the DUT. A few directed spot checks cover the documented cases.
// ---------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int NS  = 5;
    localparam int DEC = 1;
    localparam int TO  = 8;
    localparam int CW  = 32;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic          run_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [NS-1:0] stage_done_i = '0;
    logic [NS-1:0] skip_mask_i = '0;
    logic [NS-1:0] go_o;
    logic [2:0]    stage_o;
    logic          busy_o;
    logic          retire_o;
    logic [CW-1:0] instr_count_o;
    logic [CW-1:0] cycle_count_o;
    logic          timeout_o;

    stage_sequencer #(
        .NUM_STAGES   (NS),
        .DECODE_STAGE (DEC),
        .CNT_W        (CW),
        .TIMEOUT      (TO)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .run_i         (run_i),
        .stage_done_i  (stage_done_i),
        .skip_mask_i   (skip_mask_i),
        .flush_i       (flush_i),
        .go_o          (go_o),
        .stage_o       (stage_o),
        .busy_o        (busy_o),
        .retire_o      (retire_o),
        .instr_count_o (instr_count_o),
        .cycle_count_o (cycle_count_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] go;
        int            stage;
        bit            busy;
        bit            retire;
        bit            tmo;
        int unsigned   instr;
        int unsigned   cyc;
        int            cycle;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int cyc_no  = 0;

    // Reference model state.
    int            m_state;
    int            m_stage;
    int            m_wait;   // cycles the current stage has been active, incl. this one
    bit [NS-1:0]   m_skip;
    int unsigned   m_instr;
    int unsigned   m_cyc;
    bit            m_tmo;

    task automatic m_reset();
        m_state = S_IDLE;
        m_stage = 0;
        m_wait  = 0;
        m_skip  = '0;
        m_instr = 0;
        m_cyc   = 0;
        m_tmo   = 1'b0;
    endtask

    // Expected outputs for the current cycle, then advance to the next cycle.
    task automatic model_cycle(input bit run, input logic [NS-1:0] done,
                               input logic [NS-1:0] skip, input bit flush, input bit rst);
        exp_t e;
        bit   fin;
        int   nxt;
        e.go     = (m_state == S_RUN) ? (NS'(1) << m_stage) : '0;
        e.stage  = m_stage;
        e.busy   = (m_state == S_RUN);
        e.tmo    = m_tmo;
        e.instr  = m_instr;
        e.cyc    = m_cyc;
        e.cycle  = cyc_no;
        fin = (m_state == S_RUN) && (done[m_stage] === 1'b1);
        nxt = -1;
        if (fin) begin
            for (int j = m_stage + 1; j < NS; j++) begin
                bit skipped;
                skipped = (j > DEC) && ((m_stage == DEC) ? (skip[j] === 1'b1) : m_skip[j]);
                if (!skipped && nxt < 0) nxt = j;
            end
        end
        e.retire = fin && !flush && (nxt < 0);
        exp_q.push_back(e);

        if (rst) begin
            m_reset();
        end else if (m_state == S_IDLE) begin
            if (run) begin
                m_state = S_RUN;
                m_stage = 0;
                m_wait  = 1;
            end
        end else if (m_state == S_RUN) begin
            m_cyc++;
            if (flush) begin
                m_stage = 0;
                m_skip  = '0;
                m_wait  = 1;
                if (!run) m_state = S_IDLE;
            end else if (fin) begin
                if (m_stage == DEC) m_skip = skip;
                if (nxt >= 0) begin
                    m_stage = nxt;
                    m_wait  = 1;
                end else begin
                    m_instr++;
                    m_skip  = '0;
                    m_stage = 0;
                    m_wait  = 1;
                    if (!run) m_state = S_IDLE;
                end
            end else if (m_wait == TO) begin
                m_state = S_HALT;
                m_tmo   = 1'b1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic step(input bit run, input logic [NS-1:0] done,
                        input logic [NS-1:0] skip, input bit flush, input bit rst);
        @(posedge clk);
        #1;
        run_i        = run;
        stage_done_i = done;
        skip_mask_i  = skip;
        flush_i      = flush;
        nreset       = rst;
        cyc_no++;
        model_cycle(run, done, skip, flush, rst);
    endtask

    task automatic rand_step(input bit allow_rst);
        step($urandom_range(0, 9) != 0, NS'($urandom), NS'($urandom),
             $urandom_range(0, 15) == 0, allow_rst && ($urandom_range(0, 79) == 0));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (chk_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (go_o !== e.go || stage_o !== 3'(e.stage) || busy_o !== e.busy ||
                retire_o !== e.retire || timeout_o !== e.tmo ||
                instr_count_o !== e.instr || cycle_count_o !== e.cyc) begin
                n_fail++;
                $display("FAIL cycle%0d got/exp: go=%h/%h stage=%0d/%0d busy=%b/%b retire=%b/%b tmo=%b/%b instr=%0d/%0d cycles=%0d/%0d",
                         e.cycle, go_o, e.go, stage_o, e.stage, busy_o, e.busy, retire_o, e.retire,
                         timeout_o, e.tmo, instr_count_o, e.instr, cycle_count_o, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Reset state, then continuous run with every done high.
        step(1, '1, '0, 0, 0);
        #1;
        chk("reset_go", 32'(go_o), 0);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_instr", instr_count_o, 0);
        chk("reset_cycles", cycle_count_o, 0);
        chk("reset_timeout", 32'(timeout_o), 0);
        for (int i = 2; i <= 22; i++) step(1, '1, '0, 0, 0);
        #1;
        chk("run20_instr", instr_count_o, 4);
        chk("run20_cycles", cycle_count_o, 20);

        // Skip DM only, then skip everything after RF.
        for (int i = 0; i < 12; i++) step(1, '1, 5'b01000, 0, 0);
        for (int i = 0; i < 8; i++) step(1, '1, 5'b11111, 0, 0);

        // Flush during EX together with its done.
        for (int i = 0; i < 10 && !(m_state == S_RUN && m_stage == 2); i++) step(1, '1, '0, 0, 0);
        step(1, 5'b00100, '0, 1, 0);
        #1;
        chk("flush_retire", 32'(retire_o), 0);
        step(1, '1, '0, 0, 0);
        #1;
        chk("flush_go", 32'(go_o), 1);

        // Drop run at RF: the instruction finishes, then idle.
        for (int i = 0; i < 10 && !(m_state == S_RUN && m_stage == 1); i++) step(1, '1, '0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, '1, '0, 0, 0);
        #1;
        chk("stop_go", 32'(go_o), 0);
        chk("stop_busy", 32'(busy_o), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) rand_step(1'b1);

        // Watchdog: DM never completes.
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 14; i++) step(1, 5'h17, '0, 0, 0);
        #1;
        chk("wdog_go", 32'(go_o), 0);
        chk("wdog_timeout", 32'(timeout_o), 1);
        chk("wdog_stage", 32'(stage_o), 3);
        for (int i = 0; i < 10; i++) rand_step(1'b0);
        #1;
        chk("halt_hold_timeout", 32'(timeout_o), 1);
        chk("halt_hold_stage", 32'(stage_o), 3);

        // Reset pulse in the middle of an instruction.
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, '1, '0, 0, 0);
        step(1, '1, '0, 0, 1);
        step(1, '1, '0, 0, 0);
        #1;
        chk("midrst_go", 32'(go_o), 0);
        chk("midrst_instr", instr_count_o, 0);
        chk("midrst_cycles", cycle_count_o, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
